xy2_point_feeder: RTL and testbench

Upstream feeder for the XY2-100 galvo transmitter. It buffers XY scan points written by the pattern or host logic in a small FIFO. It issues exactly one point per fixed frame period to the transmitter using its `send_en` / `x_data` / `y_data` / `xy2_state` / `txdone` interface. On FIFO underrun it re-sends the last point so the mirrors hold position. Sticky status flags report overflow, underrun and late frames.

---
 rtl/xy2_point_feeder.sv | 220 ++++++++++++++++++++++
 tb/tb_xy2_point_feeder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xy2_point_feeder.sv
// xy2_point_feeder: buffers XY scan points in a small FIFO and hands exactly
// one point per frame period to the XY2-100 transmitter. When the FIFO runs
// dry the last point is re-sent so the mirrors hold position. Sticky flags
// report dropped writes, underruns and frame ticks that arrive while a frame
// is still in flight.
module xy2_point_feeder #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned PERIOD     = 550,
    parameter logic [15:0] CENTER     = 16'h8000
) (
    input  logic                  clk50m,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [15:0]           wr_x,
    input  logic [15:0]           wr_y,
    input  logic                  enable,
    input  logic                  clr_flags,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  send_en,
    output logic [15:0]           x_data,
    output logic [15:0]           y_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  underrun,
    output logic                  late
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned TW    = $clog2(PERIOD);

    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [TW-1:0]         TMR_MAX  = TW'(PERIOD - 1);
    localparam logic [TW-1:0]         TMR_ONE  = TW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  pend_q, pend_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           x_q, x_d;
    logic [15:0]           y_q, y_d;
    logic                  ovf_q, ovf_d;
    logic                  und_q, und_d;
    logic                  late_q, late_d;

    logic [15:0] mem_x [DEPTH];
    logic [15:0] mem_y [DEPTH];

    logic timer_run;
    logic tick;
    logic push;
    logic drop;
    logic pop;
    logic und_set;
    logic late_set;
    logic fifo_full;
    logic fifo_empty;

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);

    // Write side decisions use the occupancy from before this cycle, so a
    // simultaneous pop never rescues a write into a full FIFO.
    assign push = wr_en & ~fifo_full;
    assign drop = wr_en & fifo_full;

    // The frame timer only runs once the FSM has left IDLE, which places the
    // first tick PERIOD cycles after enable is first sampled high.
    assign timer_run = enable && (state_q != ST_IDLE);
    assign tick      = timer_run && (timer_q == TMR_MAX);

    // Period timer: free-running while scheduling, parked at zero otherwise.
    always_comb begin
        timer_d = timer_q;
        if (!timer_run) begin
            timer_d = '0;
        end else if (tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TMR_ONE;
        end
    end

    // Frame scheduler: decides when to pop/hold and when to pulse send_en.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        pop      = 1'b0;
        und_set  = 1'b0;
        late_set = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                end else if ((tick || pend_q) && !tx_busy) begin
                    state_d = ST_ISSUE;
                    pend_d  = 1'b0;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        und_set = 1'b1;
                    end
                end else if (tick) begin
                    pend_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                if (tick) begin
                    late_set = 1'b1;
                    pend_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    late_set = 1'b1;
                    pend_d   = 1'b1;
                end
                if (tx_done) begin
                    if (enable) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    // FIFO pointers, occupancy, output point and sticky flags.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        x_d    = pop ? mem_x[rd_ptr_q] : x_q;
        y_d    = pop ? mem_y[rd_ptr_q] : y_q;
        // A set event in the same cycle as clr_flags keeps the flag set.
        ovf_d  = drop     | (ovf_q  & ~clr_flags);
        und_d  = und_set  | (und_q  & ~clr_flags);
        late_d = late_set | (late_q & ~clr_flags);
    end

    // Point storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk50m) begin
        if (push) begin
            mem_x[wr_ptr_q] <= wr_x;
            mem_y[wr_ptr_q] <= wr_y;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            pend_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            x_q      <= CENTER;
            y_q      <= CENTER;
            ovf_q    <= 1'b0;
            und_q    <= 1'b0;
            late_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ovf_q    <= ovf_d;
            und_q    <= und_d;
            late_q   <= late_d;
        end
    end

    assign send_en  = (state_q == ST_ISSUE);
    assign x_data   = x_q;
    assign y_data   = y_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign level    = level_q;
    assign overflow = ovf_q;
    assign underrun = und_q;
    assign late     = late_q;

endmodule

// File: tb/tb_xy2_point_feeder.sv
// Directed bench for xy2_point_feeder with a behavioural transmitter that
// answers each send_en with tx_done a programmable number of cycles later.
module tb_xy2_point_feeder;

    logic        clk50m = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_x;
    logic [15:0] wr_y;
    logic        enable;
    logic        clr_flags;
    logic        tx_busy;
    logic        tx_done;
    logic        send_en;
    logic [15:0] x_data;
    logic [15:0] y_data;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        underrun;
    logic        late;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int n_send   = 0;
    int tx_delay = 525;

    xy2_point_feeder #(
        .DEPTH_LOG2 (4),
        .PERIOD     (550),
        .CENTER     (16'h8000)
    ) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .enable    (enable),
        .clr_flags (clr_flags),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .send_en   (send_en),
        .x_data    (x_data),
        .y_data    (y_data),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow),
        .underrun  (underrun),
        .late      (late)
    );

    always #10 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    always @(negedge clk50m) if (send_en === 1'b1) n_send <= n_send + 1;

    // Transmitter model: busy from send_en until tx_done, tx_done one cycle.
    initial begin
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk50m);
            if (send_en === 1'b1) begin
                tx_busy = 1'b1;
                repeat (tx_delay) @(negedge clk50m);
                tx_busy = 1'b0;
                tx_done = 1'b1;
                @(negedge clk50m);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got cycle %0d expected finish before 60000", cyc);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_pt(input logic [15:0] x, input logic [15:0] y);
        @(posedge clk50m);
        #1;
        wr_en = 1'b1;
        wr_x  = x;
        wr_y  = y;
        @(posedge clk50m);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk50m);
        #1;
        clr_flags = 1'b1;
        @(posedge clk50m);
        #1;
        clr_flags = 1'b0;
        @(negedge clk50m);
    endtask

    task automatic wait_send(input string tag, output int at, output logic [31:0] xy);
        at = -1;
        xy = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk50m);
            if (send_en === 1'b1) begin
                at = cyc;
                xy = {x_data, y_data};
                return;
            end
        end
        check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int          at;
    int          prev;
    int          c0;
    int          n0;
    logic [31:0] xy;
    logic [31:0] pts [3];
    logic [15:0] ex;
    logic [15:0] ey;

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_x      = '0;
        wr_y      = '0;
        enable    = 1'b0;
        clr_flags = 1'b0;
        pts[0]    = 32'h1111_2222;
        pts[1]    = 32'h3333_4444;
        pts[2]    = 32'h5555_6666;

        // Reset values
        repeat (3) @(posedge clk50m);
        #1;
        rst = 1'b0;
        @(negedge clk50m);
        check_eq("rst_send_en", {31'd0, send_en}, 32'd0);
        check_eq("rst_xy", {x_data, y_data}, 32'h8000_8000);
        check_eq("rst_full_empty", {30'd0, full, empty}, 32'd1);
        check_eq("rst_level", {27'd0, level}, 32'd0);
        check_eq("rst_flags", {29'd0, overflow, underrun, late}, 32'd0);

        // First point: send_en 551 cycles after enable
        write_pt(16'h1234, 16'hABCD);
        @(negedge clk50m);
        check_eq("wr1_level", {27'd0, level}, 32'd1);
        check_eq("wr1_empty", {31'd0, empty}, 32'd0);
        @(posedge clk50m);
        #1;
        enable = 1'b1;
        c0 = cyc;
        wait_send("first", at, xy);
        check_eq("first_delay", at - c0, 32'd551);
        check_eq("first_xy", xy, 32'h1234_ABCD);
        check_eq("first_level", {27'd0, level}, 32'd0);
        @(negedge clk50m);
        check_eq("send_en_width", {31'd0, send_en}, 32'd0);
        prev = at;

        // Three points in steady state, then an underrun re-send
        for (int k = 0; k < 3; k++) write_pt(pts[k][31:16], pts[k][15:0]);
        for (int k = 0; k < 3; k++) begin
            wait_send("steady", at, xy);
            check_eq("steady_spacing", at - prev, 32'd550);
            check_eq("steady_xy", xy, pts[k]);
            prev = at;
        end
        check_eq("steady_underrun", {31'd0, underrun}, 32'd0);
        wait_send("hold", at, xy);
        check_eq("hold_spacing", at - prev, 32'd550);
        check_eq("hold_xy", xy, pts[2]);
        check_eq("hold_underrun", {31'd0, underrun}, 32'd1);
        check_eq("hold_level", {27'd0, level}, 32'd0);

        // Drop enable mid-frame: no further send_en, then re-enable from IDLE
        repeat (100) @(posedge clk50m);
        #1;
        enable = 1'b0;
        n0 = n_send;
        repeat (1200) @(posedge clk50m);
        check_eq("disabled_no_send", n_send, n0);
        #1;
        enable = 1'b1;
        c0 = cyc;
        wait_send("reenable", at, xy);
        check_eq("reenable_delay", at - c0, 32'd551);
        check_eq("reenable_xy", xy, pts[2]);
        @(posedge clk50m);
        #1;
        enable = 1'b0;
        repeat (700) @(posedge clk50m);
        pulse_clr();
        check_eq("clr_flags_all", {29'd0, overflow, underrun, late}, 32'd0);

        // Fill 16 then one extra: the 17th is dropped
        for (int i = 0; i < 16; i++) write_pt(16'h0100 + 16'(i), 16'h0200 + 16'(i));
        @(negedge clk50m);
        check_eq("fill16_level", {27'd0, level}, 32'd16);
        check_eq("fill16_full", {31'd0, full}, 32'd1);
        check_eq("fill16_overflow", {31'd0, overflow}, 32'd0);
        write_pt(16'h0110, 16'h0210);
        @(negedge clk50m);
        check_eq("fill17_overflow", {31'd0, overflow}, 32'd1);
        check_eq("fill17_level", {27'd0, level}, 32'd16);
        pulse_clr();
        check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);
        check_eq("ovf_cleared_full", {31'd0, full}, 32'd1);

        // Drain all 16 in order, then re-send the 16th (never the 17th)
        @(posedge clk50m);
        #1;
        enable = 1'b1;
        prev = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            wait_send("drain", at, xy);
            check_eq("drain_spacing", at - prev, 32'd550);
            ex = 16'h0100 + 16'(i);
            ey = 16'h0200 + 16'(i);
            check_eq("drain_xy", xy, {ex, ey});
            prev = at;
        end
        check_eq("drain_empty", {31'd0, empty}, 32'd1);
        check_eq("drain_underrun", {31'd0, underrun}, 32'd0);
        wait_send("drain_hold", at, xy);
        check_eq("drain_hold_xy", xy, 32'h010F_020F);
        check_eq("drain_hold_underrun", {31'd0, underrun}, 32'd1);
        prev = at;

        // Slow transmitter: tick lands in WAIT, pending tick issues after tx_done
        repeat (100) @(posedge clk50m);
        tx_delay = 700;
        pulse_clr();
        check_eq("late_pre_clear", {30'd0, underrun, late}, 32'd0);
        write_pt(16'hAAAA, 16'h5555);
        write_pt(16'h0F0F, 16'hF0F0);
        wait_send("late1", at, xy);
        check_eq("late1_spacing", at - prev, 32'd550);
        check_eq("late1_xy", xy, 32'hAAAA_5555);
        prev = at;
        repeat (600) @(posedge clk50m);
        @(negedge clk50m);
        check_eq("late_flag", {31'd0, late}, 32'd1);
        wait_send("late2", at, xy);
        check_eq("late2_spacing", at - prev, 32'd702);
        check_eq("late2_xy", xy, 32'h0F0F_F0F0);

        // Reset mid-WAIT with points queued
        repeat (100) @(posedge clk50m);
        tx_delay = 525;
        for (int i = 0; i < 5; i++) write_pt(16'h7000 + 16'(i), 16'h7100 + 16'(i));
        @(negedge clk50m);
        check_eq("prerst_level", {27'd0, level}, 32'd5);
        @(posedge clk50m);
        #1;
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk50m);
        check_eq("midrst_level", {27'd0, level}, 32'd0);
        check_eq("midrst_empty", {31'd0, empty}, 32'd1);
        check_eq("midrst_xy", {x_data, y_data}, 32'h8000_8000);
        check_eq("midrst_flags", {29'd0, overflow, underrun, late}, 32'd0);
        check_eq("midrst_send_en", {31'd0, send_en}, 32'd0);
        @(posedge clk50m);
        #1;
        rst = 1'b0;
        n0 = n_send;
        repeat (1200) @(posedge clk50m);
        check_eq("postrst_no_send", n_send, n0);
        #1;
        enable = 1'b1;
        c0 = cyc;
        wait_send("postrst", at, xy);
        check_eq("postrst_delay", at - c0, 32'd551);
        check_eq("postrst_xy", xy, 32'h8000_8000);
        check_eq("postrst_underrun", {31'd0, underrun}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
